// File: rtl/updown_count_tracker.sv
// updown_count_tracker: observes an up/down counter's output stream, recovers
// its counting direction and flags wraps, reversals, holds and illegal jumps.
module updown_count_tracker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             dir,
  output logic             wrap_pulse,
  output logic             rev_pulse,
  output logic             hold,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int SW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {EMPTY, TRAIN, LOCK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic [SW-1:0]    streak_q, streak_d;
  logic             cand_q, cand_d;
  logic             dir_d, wrap_d, rev_d, hold_d, err_d;
  logic [ERR_W-1:0] err_count_d;

  // Step classification relative to the previous valid sample (mod 2^WIDTH).
  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_hold, crosses;
  assign delta   = count_in - prev_q;
  assign is_up   = (delta == WIDTH'(1));
  assign is_dn   = (delta == {WIDTH{1'b1}});
  assign is_hold = (delta == '0);
  // Boundary crossing: max->0 going up, or 0->max going down.
  assign crosses = (is_up && (prev_q == {WIDTH{1'b1}})) || (is_dn && (prev_q == '0));

  // Next-state and pulse decode; cand/dir use 0 = up, 1 = down.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    cand_d      = cand_q;
    dir_d       = dir;
    wrap_d      = 1'b0;
    rev_d       = 1'b0;
    hold_d      = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count;
    if (sample_valid) begin
      unique case (state_q)
        EMPTY: begin
          state_d  = TRAIN;
          streak_d = '0;
        end
        TRAIN: begin
          if (is_hold) begin
            hold_d = 1'b1;
          end else if (is_up || is_dn) begin
            if (is_dn == cand_q) begin
              streak_d = streak_q + 1'b1;
            end else begin
              cand_d   = is_dn;
              streak_d = SW'(1);
            end
            if (streak_d == SW'(LOCK_CNT)) begin
              state_d = LOCK;
              dir_d   = cand_d;
            end
          end else begin
            streak_d = '0;
          end
        end
        LOCK: begin
          if (is_hold) begin
            hold_d = 1'b1;
          end else if (is_up || is_dn) begin
            wrap_d = crosses;
            if (is_dn != dir) begin
              rev_d = 1'b1;
              dir_d = is_dn;
            end
          end else begin
            err_d    = 1'b1;
            state_d  = TRAIN;
            streak_d = '0;
            if (err_count != {ERR_W{1'b1}}) err_count_d = err_count + 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, sample history and registered outputs; pulses clear every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      prev_q     <= '0;
      streak_q   <= '0;
      cand_q     <= 1'b0;
      locked     <= 1'b0;
      dir        <= 1'b0;
      wrap_pulse <= 1'b0;
      rev_pulse  <= 1'b0;
      hold       <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      cand_q     <= cand_d;
      locked     <= (state_d == LOCK);
      dir        <= dir_d;
      wrap_pulse <= wrap_d;
      rev_pulse  <= rev_d;
      hold       <= hold_d;
      err_pulse  <= err_d;
      err_count  <= err_count_d;
      if (sample_valid) prev_q <= count_in;
    end
  end

endmodule

// File: tb/tb_updown_count_tracker.sv
// Bench for updown_count_tracker: directed vector table, hand-written corner
// sequences, then randomized traffic against a run-length reference model.
module tb_updown_count_tracker;

  logic       clk = 1'b0;
  logic       reset, sample_valid;
  logic [3:0] count_in;
  logic       locked, dir, wrap_pulse, rev_pulse, hold, err_pulse;
  logic [7:0] err_count;

  int nvec = 0;
  int nbad = 0;

  updown_count_tracker #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .count_in(count_in),
    .locked(locked), .dir(dir), .wrap_pulse(wrap_pulse), .rev_pulse(rev_pulse),
    .hold(hold), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit v; logic [3:0] c;
    bit lk; bit dr; bit wr; bit rv; bit hd; bit er; int ec;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [13:0] pk(bit lk, bit dr, bit wr, bit rv, bit hd, bit er, int ec);
    logic [31:0] e;
    e = ec;
    return {lk, dr, wr, rv, hd, er, e[7:0]};
  endfunction

  task automatic chk(string nm, logic [13:0] exp);
    logic [13:0] act;
    act = {locked, dir, wrap_pulse, rev_pulse, hold, err_pulse, err_count};
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got lk/dir/wrap/rev/hold/err=%b cnt=%0d, want %b cnt=%0d",
               nm, act[13:8], act[7:0], exp[13:8], exp[7:0]);
    end
  endtask

  // Drive away from the active edge, then sample 1 time unit after it.
  task automatic step(bit r, bit v, logic [3:0] c);
    @(negedge clk);
    reset = r; sample_valid = v; count_in = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: signed run length (+n up / -n down) and plain arithmetic.
  int m_prev, m_run, m_err;
  bit m_have, m_lock, m_dir, m_wr, m_rv, m_hd, m_er;

  task automatic model(bit r, bit v, int c);
    int d;
    bit down;
    m_wr = 0; m_rv = 0; m_hd = 0; m_er = 0;
    if (r) begin
      m_prev = 0; m_run = 0; m_err = 0; m_have = 0; m_lock = 0; m_dir = 0;
    end else if (v) begin
      d = (c - m_prev + 16) % 16;
      if (!m_have) begin
        m_have = 1; m_run = 0;
      end else if (d == 0) begin
        m_hd = 1;
      end else if (d == 1 || d == 15) begin
        down = (d == 15);
        if (m_lock) begin
          m_wr = down ? (m_prev == 0) : (m_prev == 15);
          if (down != m_dir) begin m_rv = 1; m_dir = down; end
        end else begin
          if (down) m_run = (m_run < 0) ? m_run - 1 : -1;
          else      m_run = (m_run > 0) ? m_run + 1 : 1;
          if (m_run >= 2 || m_run <= -2) begin m_lock = 1; m_dir = (m_run < 0); end
        end
      end else begin
        if (m_lock) begin
          m_er = 1; m_lock = 0;
          if (m_err < 255) m_err++;
        end
        m_run = 0;
      end
      m_prev = c;
    end
  endtask

  task automatic add(bit r, bit v, int c, bit lk, bit dr, bit wr, bit rv, bit hd, bit er, int ec);
    vec_t t;
    t.rst = r; t.v = v; t.c = 4'(c);
    t.lk = lk; t.dr = dr; t.wr = wr; t.rv = rv; t.hd = hd; t.er = er; t.ec = ec;
    tbl.push_back(t);
  endtask

  initial begin
    int p, j;
    logic [3:0] c;
    bit r, v;
    reset = 1'b1; sample_valid = 1'b0; count_in = '0;

    // Reset for three cycles with random inputs: everything reads zero.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      chk("reset", pk(0, 0, 0, 0, 0, 0, 0));
    end

    // lock on 0,1,2
    add(0,1,0,  0,0,0,0,0,0,0);
    add(0,1,1,  0,0,0,0,0,0,0);
    add(0,1,2,  1,0,0,0,0,0,0);
    add(0,1,3,  1,0,0,0,0,0,0);
    // locked up through the wrap
    add(1,0,0,  0,0,0,0,0,0,0);
    add(0,1,12, 0,0,0,0,0,0,0);
    add(0,1,13, 0,0,0,0,0,0,0);
    add(0,1,14, 1,0,0,0,0,0,0);
    add(0,1,15, 1,0,0,0,0,0,0);
    add(0,1,0,  1,0,1,0,0,0,0);
    add(0,1,1,  1,0,0,0,0,0,0);
    // reversal, down wrap, then reversal that also wraps
    add(1,0,0,  0,0,0,0,0,0,0);
    add(0,1,3,  0,0,0,0,0,0,0);
    add(0,1,4,  0,0,0,0,0,0,0);
    add(0,1,5,  1,0,0,0,0,0,0);
    add(0,1,4,  1,1,0,1,0,0,0);
    add(0,1,3,  1,1,0,0,0,0,0);
    add(0,1,2,  1,1,0,0,0,0,0);
    add(0,1,1,  1,1,0,0,0,0,0);
    add(0,1,0,  1,1,0,0,0,0,0);
    add(0,1,15, 1,1,1,0,0,0,0);
    add(0,1,0,  1,0,1,1,0,0,0);
    // illegal jump while locked, then relock
    add(1,0,0,  0,0,0,0,0,0,0);
    add(0,1,1,  0,0,0,0,0,0,0);
    add(0,1,2,  0,0,0,0,0,0,0);
    add(0,1,3,  1,0,0,0,0,0,0);
    add(0,1,9,  0,0,0,0,0,1,1);
    add(0,1,10, 0,0,0,0,0,0,1);
    add(0,1,11, 1,0,0,0,0,0,1);
    // hold across invalid gaps, then reset mid-lock
    add(0,1,12, 1,0,0,0,0,0,1);
    add(0,0,3,  1,0,0,0,0,0,1);
    add(0,0,9,  1,0,0,0,0,0,1);
    add(0,1,12, 1,0,0,0,1,0,1);
    add(0,0,0,  1,0,0,0,0,0,1);
    add(1,1,6,  0,0,0,0,0,0,0);
    add(0,1,4,  0,0,0,0,0,0,0);
    add(0,1,5,  0,0,0,0,0,0,0);
    add(0,1,6,  1,0,0,0,0,0,0);
    // hold while training leaves the streak alone
    add(1,0,0,  0,0,0,0,0,0,0);
    add(0,1,8,  0,0,0,0,0,0,0);
    add(0,1,7,  0,0,0,0,0,0,0);
    add(0,1,7,  0,0,0,0,1,0,0);
    add(0,1,6,  1,1,0,0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].c);
      chk($sformatf("vec%0d", i),
          pk(tbl[i].lk, tbl[i].dr, tbl[i].wr, tbl[i].rv, tbl[i].hd, tbl[i].er, tbl[i].ec));
    end

    // err_count saturation: lock, jump, relock, repeated past 255 errors.
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b1, 4'd2);
    chk("sat_lock", pk(1, 0, 0, 0, 0, 0, 0));
    p = 2;
    for (int i = 0; i < 260; i++) begin
      j = (p + 5) % 16;
      step(1'b0, 1'b1, 4'(j));
      chk($sformatf("sat_err%0d", i), pk(0, 0, 0, 0, 0, 1, (i + 1 > 255) ? 255 : i + 1));
      step(1'b0, 1'b1, 4'((j + 1) % 16));
      step(1'b0, 1'b1, 4'((j + 2) % 16));
      p = (j + 2) % 16;
    end
    chk("sat_final", pk(1, 0, 0, 0, 0, 0, 255));

    // Randomized traffic against the reference model.
    step(1'b1, 1'b0, 4'd0);
    model(1'b1, 1'b0, 0);
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) != 0);
      j = $urandom_range(0, 9);
      if (j < 4)      c = 4'((m_prev + 1) % 16);
      else if (j < 7) c = 4'((m_prev + 15) % 16);
      else if (j < 8) c = 4'(m_prev);
      else            c = 4'($urandom_range(0, 15));
      step(r, v, c);
      model(r, v, int'(c));
      chk($sformatf("rand%0d", i), pk(m_lock, m_dir, m_wr, m_rv, m_hd, m_er, m_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
